setpoint_store: RTL and testbench
=================================

// Module: setpoint_store
// PURPOSE
//  Consumer of the menu adjust codes. Holds the greenhouse setpoints: temperature (F),
//  relative humidity (%) and clock time (hour:minute). Decodes temp_adjust, hum_adjust
//  and time_adjust into single bounded steps and presents registered setpoints to the
//  control loop and the display. One step per press; held codes do not run away.
// PARAMETERS
//  TEMP_DEFAULT  72      temp_set reset value (F)
//  TEMP_MIN      50      temp_set lower saturation bound
//  TEMP_MAX      95      temp_set upper saturation bound
//  HUM_DEFAULT   60      hum_set reset value (%)
//  HUM_MIN       20      hum_set lower saturation bound
//  HUM_MAX       90      hum_set upper saturation bound
//  REPEAT_DELAY  2000000 held cycles before the first auto-repeat step (AUTO_REPEAT_EN only)
//  REPEAT_RATE   500000  cycles between later auto-repeat steps (AUTO_REPEAT_EN only)
// PORTS
//  clk          in   1  system clock; one clock domain
//  rst_n        in   1  reset, synchronous, active-low
//  temp_adjust  in   2  0=none 1=up 2=down 3=ignored
//  hum_adjust   in   2  0=none 1=up 2=down 3=ignored
//  time_adjust  in   3  0=none 1=min up 2=min down 3=hour up 4=hour down 5..7=ignored
//  temp_set     out  7  temperature setpoint, F
//  hum_set      out  7  humidity setpoint, %
//  hour_set     out  5  hour setpoint, 0..23
//  min_set      out  6  minute setpoint, 0..59
//  changed      out  1  one-cycle pulse in any cycle where a setpoint value changed
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge clk): temp_set=TEMP_DEFAULT, hum_set=HUM_DEFAULT,
//    hour_set=12, min_set=0, changed=0. All prev-code registers=0, all repeat counters=0.
//    Reset mid-press aborts the press. A code held across reset release counts as a new
//    press and steps in the first cycle after release.
//  - Per channel (temp, hum, time): prev register holds the last sampled code. A press
//    event occurs when code!=0, code is valid, and code!=prev. Valid-to-different-valid
//    changes are new presses. Invalid codes behave as 0 for stepping. prev updates every cycle.
//  - Latency: code sampled at edge N; the setpoint and changed update at edge N+1.
//  - temp/hum: +1/-1 per event, saturating at [MIN,MAX]. A step at a bound leaves the value
//    unchanged and does not assert changed.
//  - minute: +1/-1 modulo 60 (59->0, 0->59). No carry into hour.
//  - hour: +1/-1 modulo 24 (23->0, 0->23).
//  - Channels are independent. Simultaneous events on all three channels apply in the
//    same cycle. changed is the OR of the per-field change flags.
//  - Parameter legality: MIN<=DEFAULT<=MAX<=127. The block does not check these at run time.
// CONFIGURATION
//  AUTO_REPEAT_EN defined: each channel has a 22-bit hold counter.
//    - Counter clears to 0 on any press event and whenever the code is 0 or invalid.
//    - Counter increments while code==prev!=0.
//    - One extra step is issued when the counter reaches REPEAT_DELAY. The counter then
//      reloads to REPEAT_DELAY-REPEAT_RATE, so later steps come every REPEAT_RATE cycles.
//    - Repeat steps follow the same saturation and wrap rules as press steps.
//  AUTO_REPEAT_EN undefined: no hold counters. Exactly one step per press, whatever the hold length.
// TESTING
//  1 reset: rst_n low 2 cycles -> temp_set=72 hum_set=60 hour_set=12 min_set=0 changed=0
//  2 temp_adjust=1 held 10 cycles -> temp_set=73 one cycle after first sample, single
//    changed pulse. Then =2 for 1 cycle, =0 for 1 cycle, =2 for 1 cycle -> 71.
//  3 hum_adjust 0/1 pulses x40 from 60 -> hum_set reaches 90, then stays 90. changed
//    pulses on exactly 30 of the presses.
//  4 time_adjust=4 press at hour 0 -> hour_set=23. time_adjust=1 press at min 59 ->
//    min_set=0 and hour_set unchanged. time_adjust=6 -> no change, changed=0.
//  5 same cycle temp_adjust=2, hum_adjust=1, time_adjust=3 from reset -> 71/61/13 in one
//    cycle, changed high for 1 cycle. Reset asserted while codes held -> defaults restored.
//  6 AUTO_REPEAT_EN, REPEAT_DELAY=8, REPEAT_RATE=4: temp_adjust=1 held 20 cycles from 72
//    -> steps at cycles 1, 9, 13, 17 -> 76. Without the macro -> 73.

Source files
------------

// File: rtl/setpoint_store.sv
`default_nettype none
// ============================================================================
//  Module   : setpoint_store
//  Purpose  : Holds the greenhouse setpoints (temperature, humidity, hour and
//             minute). Decodes the menu adjust codes into single bounded steps,
//             one step per press, and presents registered setpoints.
//  Ports    : clk          - system clock
//             rst_n        - synchronous active-low reset
//             temp_adjust  - 0 none, 1 up, 2 down, 3 ignored
//             hum_adjust   - 0 none, 1 up, 2 down, 3 ignored
//             time_adjust  - 0 none, 1 min up, 2 min down, 3 hour up,
//                            4 hour down, 5..7 ignored
//             temp_set     - temperature setpoint (F), saturating
//             hum_set      - humidity setpoint (%), saturating
//             hour_set     - hour setpoint 0..23, wraps
//             min_set      - minute setpoint 0..59, wraps, no carry to hour
//             changed      - one-cycle pulse whenever any setpoint changed
//  Options  : AUTO_REPEAT_EN - when defined, a held code auto-repeats after
//             REPEAT_DELAY cycles and then every REPEAT_RATE cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module setpoint_store #(
    parameter int TEMP_DEFAULT = 72,
    parameter int TEMP_MIN     = 50,
    parameter int TEMP_MAX     = 95,
    parameter int HUM_DEFAULT  = 60,
    parameter int HUM_MIN      = 20,
    parameter int HUM_MAX      = 90,
    parameter int REPEAT_DELAY = 2000000,
    parameter int REPEAT_RATE  = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] temp_adjust,
    input  logic [1:0] hum_adjust,
    input  logic [2:0] time_adjust,
    output logic [6:0] temp_set,
    output logic [6:0] hum_set,
    output logic [4:0] hour_set,
    output logic [5:0] min_set,
    output logic       changed
);

    localparam logic [6:0]  c_TEMP_DEF   = 7'(TEMP_DEFAULT);
    localparam logic [6:0]  c_TEMP_MIN   = 7'(TEMP_MIN);
    localparam logic [6:0]  c_TEMP_MAX   = 7'(TEMP_MAX);
    localparam logic [6:0]  c_HUM_DEF    = 7'(HUM_DEFAULT);
    localparam logic [6:0]  c_HUM_MIN    = 7'(HUM_MIN);
    localparam logic [6:0]  c_HUM_MAX    = 7'(HUM_MAX);
    // The hold counter never actually holds REPEAT_DELAY: the cycle it would
    // get there, the repeat step fires and the counter reloads instead.
    localparam logic [21:0] c_RPT_LAST   = 22'(REPEAT_DELAY - 1);
    localparam logic [21:0] c_RPT_RELOAD = 22'(REPEAT_DELAY - REPEAT_RATE);

    // Sampled code and the code sampled one cycle earlier, per channel.
    logic [1:0] r_temp_code, r_temp_prev;
    logic [1:0] r_hum_code,  r_hum_prev;
    logic [2:0] r_time_code, r_time_prev;

    logic [6:0] r_temp_set, r_hum_set;
    logic [4:0] r_hour_set;
    logic [5:0] r_min_set;
    logic       r_changed;

    // Channel index: 0 temperature, 1 humidity, 2 time.
    logic [2:0] w_valid, w_same, w_press, w_held, w_rpt, w_step;
    logic [6:0] w_temp_next, w_hum_next;
    logic [4:0] w_hour_next;
    logic [5:0] w_min_next;
    logic       w_any_chg;

    assign w_valid[0] = (r_temp_code == 2'd1) || (r_temp_code == 2'd2);
    assign w_valid[1] = (r_hum_code  == 2'd1) || (r_hum_code  == 2'd2);
    assign w_valid[2] = (r_time_code != 3'd0) && (r_time_code <= 3'd4);

    assign w_same[0]  = (r_temp_code == r_temp_prev);
    assign w_same[1]  = (r_hum_code  == r_hum_prev);
    assign w_same[2]  = (r_time_code == r_time_prev);

    // Any change into a valid code is a new press, including valid-to-valid.
    assign w_press = w_valid & ~w_same;
    assign w_held  = w_valid &  w_same;
    assign w_step  = w_press | w_rpt;

`ifdef AUTO_REPEAT_EN
    for (genvar i = 0; i < 3; i++) begin : g_rpt
        logic [21:0] r_cnt;

        // Anything other than a steady valid code (press, idle, invalid)
        // restarts the hold time.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (!w_held[i]) begin
                r_cnt <= '0;
            end else if (r_cnt == c_RPT_LAST) begin
                r_cnt <= c_RPT_RELOAD;
            end else begin
                r_cnt <= r_cnt + 22'd1;
            end
        end

        assign w_rpt[i] = w_held[i] && (r_cnt == c_RPT_LAST);
    end
`else
    logic w_unused_rpt;

    assign w_rpt        = '0;
    assign w_unused_rpt = ^{c_RPT_LAST, c_RPT_RELOAD, w_held};
`endif

    always_comb begin
        w_temp_next = r_temp_set;
        w_hum_next  = r_hum_set;
        w_hour_next = r_hour_set;
        w_min_next  = r_min_set;

        if (w_step[0]) begin
            if (r_temp_code == 2'd1 && r_temp_set < c_TEMP_MAX) begin
                w_temp_next = r_temp_set + 7'd1;
            end else if (r_temp_code == 2'd2 && r_temp_set > c_TEMP_MIN) begin
                w_temp_next = r_temp_set - 7'd1;
            end
        end

        if (w_step[1]) begin
            if (r_hum_code == 2'd1 && r_hum_set < c_HUM_MAX) begin
                w_hum_next = r_hum_set + 7'd1;
            end else if (r_hum_code == 2'd2 && r_hum_set > c_HUM_MIN) begin
                w_hum_next = r_hum_set - 7'd1;
            end
        end

        if (w_step[2]) begin
            case (r_time_code)
                3'd1:    w_min_next  = (r_min_set  == 6'd59) ? 6'd0  : r_min_set  + 6'd1;
                3'd2:    w_min_next  = (r_min_set  == 6'd0)  ? 6'd59 : r_min_set  - 6'd1;
                3'd3:    w_hour_next = (r_hour_set == 5'd23) ? 5'd0  : r_hour_set + 5'd1;
                3'd4:    w_hour_next = (r_hour_set == 5'd0)  ? 5'd23 : r_hour_set - 5'd1;
                default: ;
            endcase
        end

        // A step blocked at a saturation bound leaves the value alone and so
        // produces no change pulse.
        w_any_chg = (w_temp_next != r_temp_set) || (w_hum_next  != r_hum_set)
                 || (w_hour_next != r_hour_set) || (w_min_next  != r_min_set);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_temp_code <= '0;
            r_temp_prev <= '0;
            r_hum_code  <= '0;
            r_hum_prev  <= '0;
            r_time_code <= '0;
            r_time_prev <= '0;
            r_temp_set  <= c_TEMP_DEF;
            r_hum_set   <= c_HUM_DEF;
            r_hour_set  <= 5'd12;
            r_min_set   <= 6'd0;
            r_changed   <= 1'b0;
        end else begin
            r_temp_code <= temp_adjust;
            r_temp_prev <= r_temp_code;
            r_hum_code  <= hum_adjust;
            r_hum_prev  <= r_hum_code;
            r_time_code <= time_adjust;
            r_time_prev <= r_time_code;
            r_temp_set  <= w_temp_next;
            r_hum_set   <= w_hum_next;
            r_hour_set  <= w_hour_next;
            r_min_set   <= w_min_next;
            r_changed   <= w_any_chg;
        end
    end

    assign temp_set = r_temp_set;
    assign hum_set  = r_hum_set;
    assign hour_set = r_hour_set;
    assign min_set  = r_min_set;
    assign changed  = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_setpoint_store.sv
`default_nettype none
// ============================================================================
//  Module   : tb_setpoint_store
//  Purpose  : Self-checking bench for setpoint_store. A table of per-cycle
//             input/expected-output records covers reset, single press,
//             direction changes and simultaneous presses with reset; short
//             hand-written sequences cover saturation, time wrap, invalid
//             codes and auto-repeat hold behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_setpoint_store;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] temp_adjust;
    logic [1:0] hum_adjust;
    logic [2:0] time_adjust;
    logic [6:0] temp_set;
    logic [6:0] hum_set;
    logic [4:0] hour_set;
    logic [5:0] min_set;
    logic       changed;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    setpoint_store #(
        .REPEAT_DELAY (8),
        .REPEAT_RATE  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .temp_adjust (temp_adjust),
        .hum_adjust  (hum_adjust),
        .time_adjust (time_adjust),
        .temp_set    (temp_set),
        .hum_set     (hum_set),
        .hour_set    (hour_set),
        .min_set     (min_set),
        .changed     (changed)
    );

    // One record = inputs held for one clock, outputs expected just after it.
    typedef struct {
        logic       rst_n;
        logic [1:0] t;
        logic [1:0] h;
        logic [2:0] tm;
        int         e_temp;
        int         e_hum;
        int         e_hour;
        int         e_min;
        int         e_chg;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [1:0] t, input logic [1:0] h,
                                input logic [2:0] tm, input int et, input int eh,
                                input int ehr, input int em, input int ec);
        vec_t v;
        v.rst_n = r; v.t = t; v.h = h; v.tm = tm;
        v.e_temp = et; v.e_hum = eh; v.e_hour = ehr; v.e_min = em; v.e_chg = ec;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] t, input logic [1:0] h,
                         input logic [2:0] tm);
        rst_n = r; temp_adjust = t; hum_adjust = h; time_adjust = tm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 2'd0, 2'd0, 3'd0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Codes present for one cycle, then idle two cycles; counts change pulses.
    task automatic pulse(input logic [1:0] t, input logic [1:0] h, input logic [2:0] tm,
                         output int n);
        n = 0;
        drive(1'b1, t, h, tm);
        tick();
        n += int'(changed);
        drive(1'b1, 2'd0, 2'd0, 3'd0);
        tick();
        n += int'(changed);
        tick();
        n += int'(changed);
    endtask

    int n;
    int total;
    int exp_rpt_temp;
    int exp_rpt_chg;

    initial begin
        drive(1'b0, 2'd0, 2'd0, 3'd0);

        // Reset for two cycles.
        add(0, 0, 0, 0, 72, 60, 12, 0, 0);
        add(0, 0, 0, 0, 72, 60, 12, 0, 0);
        // temp up held 10 cycles: sampled on the first edge, steps on the next.
        add(1, 1, 0, 0, 72, 60, 12, 0, 0);
        add(1, 1, 0, 0, 73, 60, 12, 0, 1);
        for (int i = 0; i < 8; i++) add(1, 1, 0, 0, 73, 60, 12, 0, 0);
        // down 1 cycle, idle 1 cycle, down 1 cycle -> 71.
        add(1, 2, 0, 0, 73, 60, 12, 0, 0);
        add(1, 0, 0, 0, 72, 60, 12, 0, 1);
        add(1, 2, 0, 0, 72, 60, 12, 0, 0);
        add(1, 0, 0, 0, 71, 60, 12, 0, 1);
        add(1, 0, 0, 0, 71, 60, 12, 0, 0);
        // Reset, then simultaneous presses on all three channels.
        add(0, 0, 0, 0, 72, 60, 12, 0, 0);
        add(1, 2, 1, 3, 72, 60, 12, 0, 0);
        add(1, 2, 1, 3, 71, 61, 13, 0, 1);
        add(1, 2, 1, 3, 71, 61, 13, 0, 0);
        // Reset while the codes are still held restores the defaults.
        add(0, 2, 1, 3, 72, 60, 12, 0, 0);
        // Held code across reset release is a new press.
        add(1, 2, 1, 3, 72, 60, 12, 0, 0);
        add(1, 2, 1, 3, 71, 61, 13, 0, 1);
        add(1, 0, 0, 0, 71, 61, 13, 0, 0);
        add(1, 0, 0, 0, 71, 61, 13, 0, 0);

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].t, vecs[i].h, vecs[i].tm);
            tick();
            check($sformatf("vec%0d temp_set", i), int'(temp_set), vecs[i].e_temp);
            check($sformatf("vec%0d hum_set",  i), int'(hum_set),  vecs[i].e_hum);
            check($sformatf("vec%0d hour_set", i), int'(hour_set), vecs[i].e_hour);
            check($sformatf("vec%0d min_set",  i), int'(min_set),  vecs[i].e_min);
            check($sformatf("vec%0d changed",  i), int'(changed),  vecs[i].e_chg);
        end

        // Humidity: 40 up presses from 60 saturate at 90 after 30 of them.
        do_reset();
        total = 0;
        for (int i = 0; i < 40; i++) begin
            pulse(2'd0, 2'd1, 3'd0, n);
            total += n;
            if (i == 29) check("hum after 30 presses", int'(hum_set), 90);
        end
        check("hum saturated", int'(hum_set), 90);
        check("hum change pulses", total, 30);

        // Invalid temperature code does nothing.
        pulse(2'd3, 2'd0, 3'd0, n);
        check("temp code 3 value", int'(temp_set), 72);
        check("temp code 3 changed", n, 0);

        // Hour down from 12 to 0, then wrap to 23.
        do_reset();
        for (int i = 0; i < 12; i++) pulse(2'd0, 2'd0, 3'd4, n);
        check("hour at 0", int'(hour_set), 0);
        pulse(2'd0, 2'd0, 3'd4, n);
        check("hour wrap down", int'(hour_set), 23);
        check("hour wrap changed", n, 1);
        // Minute down from 0 wraps to 59, then up from 59 wraps to 0, no carry.
        pulse(2'd0, 2'd0, 3'd2, n);
        check("min wrap down", int'(min_set), 59);
        pulse(2'd0, 2'd0, 3'd1, n);
        check("min wrap up", int'(min_set), 0);
        check("min wrap no carry", int'(hour_set), 23);
        check("min wrap changed", n, 1);
        // Ignored time code.
        pulse(2'd0, 2'd0, 3'd6, n);
        check("time code 6 hour", int'(hour_set), 23);
        check("time code 6 min", int'(min_set), 0);
        check("time code 6 changed", n, 0);

        // Temperature held 20 cycles from 72.
`ifdef AUTO_REPEAT_EN
        exp_rpt_temp = 76;
        exp_rpt_chg  = 4;
`else
        exp_rpt_temp = 73;
        exp_rpt_chg  = 1;
`endif
        do_reset();
        total = 0;
        drive(1'b1, 2'd1, 2'd0, 3'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            total += int'(changed);
        end
        drive(1'b1, 2'd0, 2'd0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            total += int'(changed);
        end
        check("held temp value", int'(temp_set), exp_rpt_temp);
        check("held temp change pulses", total, exp_rpt_chg);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
